// File: rtl/alu8_issue_stage_if.sv
// Issue-stage bus bundle: instruction handshake, ALU drive/return, writeback and debug read.
// The slave side is the issue stage. The master side is the instruction source plus the ALU.
interface alu8_issue_stage_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_sel;
  logic [ADDR_W-1:0] in_rd;
  logic [ADDR_W-1:0] in_rs1;
  logic [ADDR_W-1:0] in_rs2;
  logic              in_imm_en;
  logic [DATA_W-1:0] in_imm;
  logic              hold;
  logic [3:0]        alu_sel;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_c;
  logic              alu_cmp;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              cmp_flag;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport slave (
    input  in_valid, in_sel, in_rd, in_rs1, in_rs2, in_imm_en, in_imm, hold,
           alu_c, alu_cmp, dbg_addr,
    output in_ready, alu_sel, alu_a, alu_b, wb_valid, wb_rd, wb_data, cmp_flag,
           dbg_data
  );

  modport master (
    output in_valid, in_sel, in_rd, in_rs1, in_rs2, in_imm_en, in_imm, hold,
           alu_c, alu_cmp, dbg_addr,
    input  in_ready, alu_sel, alu_a, alu_b, wb_valid, wb_rd, wb_data, cmp_flag,
           dbg_data
  );
endinterface

// File: rtl/alu8_issue_stage.sv
// Issue stage ahead of a combinational 8-bit ALU: register file, registered ALU operands,
// one-cycle writeback, and an EX-result bypass so dependent instructions issue back to back.
module alu8_issue_stage #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  alu8_issue_stage_if.slave  bus
);
  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] rf_q [NREG];

  logic              ex_valid_q, ex_valid_d;
  logic [ADDR_W-1:0] ex_rd_q,    ex_rd_d;
  logic [3:0]        alu_sel_q,  alu_sel_d;
  logic [DATA_W-1:0] alu_a_q,    alu_a_d;
  logic [DATA_W-1:0] alu_b_q,    alu_b_d;
  logic              wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0] wb_rd_q,    wb_rd_d;
  logic [DATA_W-1:0] wb_data_q,  wb_data_d;
  logic              cmp_q,      cmp_d;

  logic [DATA_W-1:0] op_a, op_b;
  logic              rf_we;

  // Operand fetch: the result still sitting in EX is newer than the register file.
  always_comb begin
    op_a = '0;
    op_b = '0;
    if (bus.in_rs1 != '0)
      op_a = (ex_valid_q && ex_rd_q == bus.in_rs1) ? bus.alu_c : rf_q[bus.in_rs1];
    if (bus.in_rs2 != '0)
      op_b = (ex_valid_q && ex_rd_q == bus.in_rs2) ? bus.alu_c : rf_q[bus.in_rs2];
  end

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_rd_d    = ex_rd_q;
    alu_sel_d  = alu_sel_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    cmp_d      = cmp_q;
    if (!bus.hold) begin
      if (bus.in_valid) begin
        alu_sel_d  = bus.in_sel;
        alu_a_d    = op_a;
        alu_b_d    = bus.in_imm_en ? bus.in_imm : op_b;
        ex_rd_d    = bus.in_rd;
        ex_valid_d = 1'b1;
      end else begin
        ex_valid_d = 1'b0;
      end
      if (ex_valid_q) begin
        wb_valid_d = 1'b1;
        wb_rd_d    = ex_rd_q;
        wb_data_d  = bus.alu_c;
        cmp_d      = bus.alu_cmp;
      end
    end
  end

  // r0 is never written, so it stays at its reset value of zero.
  assign rf_we = !bus.hold && ex_valid_q && (ex_rd_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      ex_valid_q <= 1'b0;
      ex_rd_q    <= '0;
      alu_sel_q  <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      cmp_q      <= 1'b0;
    end else begin
      if (rf_we) rf_q[ex_rd_q] <= bus.alu_c;
      ex_valid_q <= ex_valid_d;
      ex_rd_q    <= ex_rd_d;
      alu_sel_q  <= alu_sel_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      cmp_q      <= cmp_d;
    end
  end

  assign bus.in_ready = !bus.hold;
  assign bus.alu_sel  = alu_sel_q;
  assign bus.alu_a    = alu_a_q;
  assign bus.alu_b    = alu_b_q;
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.cmp_flag = cmp_q;
  assign bus.dbg_data = (bus.dbg_addr == '0) ? '0 : rf_q[bus.dbg_addr];
endmodule

// File: tb/tb_alu8_issue_stage.sv
// Bench for alu8_issue_stage: directed scenarios plus random traffic against an in-order
// architectural model; a small behavioural ALU closes the loop on alu_c/alu_cmp.
module tb_alu8_issue_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  alu8_issue_stage_if #(.ADDR_W(3), .DATA_W(8)) bus ();
  alu8_issue_stage #(.ADDR_W(3), .DATA_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #10 clk = ~clk;

  // Behavioural ALU: returns {cmp, result}; cmp is unsigned a<b.
  function automatic logic [8:0] alu_f(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    case (sel)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      default: r = b;
    endcase
    return {(a < b), r};
  endfunction

  always_comb {bus.alu_cmp, bus.alu_c} = alu_f(bus.alu_sel, bus.alu_a, bus.alu_b);

  // Architectural (in-order) register file, and the committed copy visible on dbg.
  logic [7:0] arch_rf [8];
  logic [7:0] cm_rf   [8];
  bit         ex_has;
  logic [2:0] ex_rd_m;
  logic [7:0] ex_c_m;
  logic       ex_cmp_m;
  logic       wbe;
  logic [2:0] wb_rd_e;
  logic [7:0] wb_data_e;
  logic       cmp_e;
  logic [3:0] sel_e;
  logic [7:0] a_e, b_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin arch_rf[i] = 8'h00; cm_rf[i] = 8'h00; end
    ex_has = 0; ex_rd_m = 0; ex_c_m = 0; ex_cmp_m = 0;
    wbe = 0; wb_rd_e = 0; wb_data_e = 0; cmp_e = 0;
    sel_e = 0; a_e = 0; b_e = 0;
  endtask

  task automatic dump_rf(input string tag);
    for (int i = 0; i < 8; i++) begin
      bus.dbg_addr = 3'(i);
      #1;
      chk(tag, {24'h0, bus.dbg_data}, {24'h0, cm_rf[i]});
    end
  endtask

  // One clock: drive at negedge, model the edge, check at the next negedge.
  task automatic step(input bit v, input logic [3:0] sel, input logic [2:0] rd,
                      input logic [2:0] rs1, input logic [2:0] rs2, input bit ie,
                      input logic [7:0] imm, input bit h);
    logic [7:0] a, b;
    logic [8:0] r;
    bus.in_valid = v; bus.in_sel = sel; bus.in_rd = rd; bus.in_rs1 = rs1;
    bus.in_rs2 = rs2; bus.in_imm_en = ie; bus.in_imm = imm; bus.hold = h;
    bus.dbg_addr = 3'($urandom_range(0, 7));
    #1;
    chk("in_ready", {31'h0, bus.in_ready}, {31'h0, !h});
    chk("dbg_data", {24'h0, bus.dbg_data}, {24'h0, cm_rf[bus.dbg_addr]});
    @(posedge clk);
    if (h) begin
      wbe = 0;
    end else begin
      wbe = ex_has;
      if (ex_has) begin
        if (ex_rd_m != 0) cm_rf[ex_rd_m] = ex_c_m;
        wb_rd_e = ex_rd_m; wb_data_e = ex_c_m; cmp_e = ex_cmp_m;
      end
      ex_has = v;
      if (v) begin
        a = (rs1 == 0) ? 8'h00 : arch_rf[rs1];
        b = ie ? imm : ((rs2 == 0) ? 8'h00 : arch_rf[rs2]);
        r = alu_f(sel, a, b);
        if (rd != 0) arch_rf[rd] = r[7:0];
        sel_e = sel; a_e = a; b_e = b;
        ex_rd_m = rd; ex_c_m = r[7:0]; ex_cmp_m = r[8];
      end
    end
    @(negedge clk);
    chk("wb_valid", {31'h0, bus.wb_valid}, {31'h0, wbe});
    chk("wb_rd",    {29'h0, bus.wb_rd},    {29'h0, wb_rd_e});
    chk("wb_data",  {24'h0, bus.wb_data},  {24'h0, wb_data_e});
    chk("cmp_flag", {31'h0, bus.cmp_flag}, {31'h0, cmp_e});
    chk("alu_sel",  {28'h0, bus.alu_sel},  {28'h0, sel_e});
    chk("alu_a",    {24'h0, bus.alu_a},    {24'h0, a_e});
    chk("alu_b",    {24'h0, bus.alu_b},    {24'h0, b_e});
  endtask

  task automatic idle(input bit h);
    step(1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, h);
  endtask

  initial begin
    bus.in_valid = 0; bus.in_sel = 0; bus.in_rd = 0; bus.in_rs1 = 0; bus.in_rs2 = 0;
    bus.in_imm_en = 0; bus.in_imm = 0; bus.hold = 0; bus.dbg_addr = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    chk("rst_wb_valid", {31'h0, bus.wb_valid}, 32'h0);
    chk("rst_cmp_flag", {31'h0, bus.cmp_flag}, 32'h0);
    chk("rst_alu_a", {24'h0, bus.alu_a}, 32'h0);
    chk("rst_alu_b", {24'h0, bus.alu_b}, 32'h0);
    dump_rf("rst_rf");

    // Immediate load into r1, then a dependent chain with no bubbles
    step(1, 4'd0, 3'd1, 3'd0, 3'd0, 1, 8'h0C, 0);
    chk("imm_alu_b", {24'h0, bus.alu_b}, 32'h0C);
    step(1, 4'd2, 3'd2, 3'd1, 3'd0, 1, 8'hF3, 0);
    chk("imm_wb_r1", {21'h0, bus.wb_valid, bus.wb_rd, bus.wb_data}, {21'h0, 1'b1, 3'd1, 8'h0C});
    chk("chain_a_r1_bypass", {24'h0, bus.alu_a}, 32'h0C);
    step(1, 4'd3, 3'd3, 3'd2, 3'd1, 0, 8'h00, 0);
    chk("chain_a_r2_bypass", {24'h0, bus.alu_a}, 32'h00);
    chk("chain_b_r1", {24'h0, bus.alu_b}, 32'h0C);
    idle(0);
    chk("chain_wb_r3", {21'h0, bus.wb_valid, bus.wb_rd, bus.wb_data}, {21'h0, 1'b1, 3'd3, 8'h0C});
    idle(0);
    dump_rf("chain_rf");

    // Write to r0 is dropped but still reported
    step(1, 4'd0, 3'd0, 3'd0, 3'd0, 1, 8'hFF, 0);
    step(1, 4'd4, 3'd4, 3'd0, 3'd1, 0, 8'h00, 0);
    chk("r0_wb_rd", {28'h0, bus.wb_valid, bus.wb_rd}, {28'h0, 1'b1, 3'd0});
    chk("r0_read_alu_a", {24'h0, bus.alu_a}, 32'h00);
    idle(0);
    dump_rf("r0_rf");

    // Hold three cycles with an instruction in EX and another pending
    step(1, 4'd1, 3'd5, 3'd1, 3'd4, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) step(1, 4'd0, 3'd6, 3'd5, 3'd0, 1, 8'h21, 1);
    step(1, 4'd0, 3'd6, 3'd5, 3'd0, 1, 8'h21, 0);
    chk("hold_release_wb_rd", {29'h0, bus.wb_rd}, 32'd5);
    idle(0);
    chk("hold_pending_wb_rd", {29'h0, bus.wb_rd}, 32'd6);
    idle(0);
    dump_rf("hold_rf");

    // Reset between accept and writeback
    step(1, 4'd0, 3'd7, 3'd0, 3'd0, 1, 8'h5A, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_wb_valid", {31'h0, bus.wb_valid}, 32'h0);
    chk("midrst_alu_sel", {28'h0, bus.alu_sel}, 32'h0);
    chk("midrst_alu_a", {24'h0, bus.alu_a}, 32'h0);
    chk("midrst_alu_b", {24'h0, bus.alu_b}, 32'h0);
    chk("midrst_wb_data", {24'h0, bus.wb_data}, 32'h0);
    chk("midrst_cmp", {31'h0, bus.cmp_flag}, 32'h0);
    dump_rf("midrst_rf");
    @(negedge clk);
    rst_n = 1'b1;
    idle(0);
    idle(0);

    // Random traffic with sporadic holds
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 9) < 8), 4'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           8'($urandom), ($urandom_range(0, 4) == 0));
    end
    idle(0);
    idle(0);
    dump_rf("final_rf");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu8_issue_stage.md
Name: alu8_issue_stage

Overview:
- Execute/issue stage directly upstream of the combinational 8-bit ALU.
- Holds an 8-entry x 8-bit register file and accepts one instruction per cycle over a valid/ready handshake.
- Drives registered sel/A/B to the ALU, captures C/cmp one cycle later, writes C back into the register file and updates the compare flag.
- Bypasses an in-flight result so back-to-back dependent instructions need no bubble.

Parameters:
- ADDR_W, 3, register address width (2^ADDR_W registers)
- DATA_W, 8, datapath width; must stay 8 to match the ALU

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction offered
- in_ready  out  1  stage can accept; equals ~hold
- in_sel  in  4  ALU operation code, passed unchanged to ALU
- in_rd  in  ADDR_W  destination register
- in_rs1  in  ADDR_W  source for ALU A
- in_rs2  in  ADDR_W  source for ALU B (unused when in_imm_en=1)
- in_imm_en  in  1  B taken from in_imm instead of register
- in_imm  in  DATA_W  immediate operand
- hold  in  1  downstream stall; freezes the stage
- alu_sel  out  4  registered to ALU sel
- alu_a  out  DATA_W  registered to ALU A
- alu_b  out  DATA_W  registered to ALU B
- alu_c  in  DATA_W  ALU result (combinational from alu_* outputs)
- alu_cmp  in  1  ALU compare output
- wb_valid  out  1  one-cycle pulse per written-back result
- wb_rd  out  ADDR_W  register written
- wb_data  out  DATA_W  value written
- cmp_flag  out  1  cmp of last retired instruction
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  DATA_W  combinational register read (r0 reads 0)

Behaviour:
- Reset (async, rst_n=0):
  - all registers r0..r7 = 0
  - ex_valid = 0; alu_sel/alu_a/alu_b = 0
  - wb_valid = 0, wb_rd = 0, wb_data = 0, cmp_flag = 0
  - Any in-flight instruction is discarded, with no write.
- Register file:
  - r0 reads 0 always; writes to r0 are dropped, but wb_valid still pulses with wb_rd=0.
  - Reads are combinational.
- Accept: an instruction is accepted when in_valid & in_ready at the rising edge. in_ready = ~hold; there is no other back-pressure.
- EX stage, edge of accept:
  - alu_sel <= in_sel
  - alu_a <= opnd(rs1)
  - alu_b <= in_imm_en ? in_imm : opnd(rs2)
  - ex_rd <= in_rd; ex_valid <= 1
  - If nothing is accepted and hold=0: ex_valid <= 0 and alu_* keep their old values.
- Operand bypass, opnd(rs):
  - rs==0 -> 0
  - else if ex_valid & ex_rd==rs & ex_rd!=0 -> alu_c
  - else regfile[rs]
  - The bypass applies to rs1 and rs2 independently.
- Writeback: on a rising edge with ex_valid & ~hold:
  - regfile[ex_rd] <= alu_c (unless r0)
  - cmp_flag <= alu_cmp
  - wb_valid <= 1, wb_rd <= ex_rd, wb_data <= alu_c
  - Otherwise wb_valid <= 0, and wb_rd/wb_data/cmp_flag hold their values.
- Latency:
  - accept at edge N -> ALU inputs valid during cycle N..N+1
  - write and wb_valid at edge N+1; the register is readable from cycle N+1 on
  - Throughput is 1 per cycle.
- Hold=1:
  - EX registers, alu_* and ex_valid are frozen; no writeback; wb_valid=0; in_ready=0; in_valid is ignored.
  - The bypass stays active from the frozen EX.
  - On release, writeback occurs at the first edge with hold=0.
- Same-cycle accept and writeback:
  - Writeback of EX and capture of the new instruction happen on the same edge.
  - The new instruction's operands use the bypass, not the stale regfile value.
- dbg_data reflects the regfile state after writes; it does not include the bypass.

Test Plan:
- Reset then debug-read r0..r7 -> all 0. cmp_flag=0, wb_valid=0, alu_a=alu_b=0.
- Imm load: sel=0, rd=1, imm=8'h0C, imm_en=1 -> next cycle alu_b=0C. Following edge wb_valid=1, wb_rd=1, wb_data=0C, dbg r1=0C.
- Back-to-back dependency: r1=0C, then r2 = r1 AND imm F3 (sel=2), then r3 = r2 OR r1 (sel=3), accepted on consecutive cycles -> alu_a for the third instruction equals the bypassed 8'h00, and r3=0C. No bubble; wb_valid high on 3 consecutive cycles.
- Write to r0 with imm 8'hFF -> wb_valid=1, wb_rd=0, dbg r0=0, and a later read of rs1=0 gives alu_a=0.
- Hold for 3 cycles while an instruction is in EX with in_valid=1 -> in_ready=0, no accept, wb_valid=0, alu_* stable. After release, exactly one writeback, then the pending instruction is accepted.
- Assert rst_n=0 mid-pipeline, between accept and writeback -> outputs reset immediately, the regfile is cleared, and no wb_valid pulse occurs after reset deasserts.
